// File: rtl/jtframe_dual_ram_arb.sv
// jtframe_dual_ram_arb
// Round-robin arbiter that lets three cs/ok requesters (CPU, DMA, debug)
// share one port of a jtframe_dual_ram. It drives the RAM port registers,
// waits out the RAM's one-cycle registered read, and returns q to the
// granted requester.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   reqN_cs/addr/din/we   (N=0..2)   request side inputs
//   reqN_dout/ok          (N=0..2)   request side results (registered)
//   ram_addr/ram_data/ram_we         to the RAM port (registered)
//   ram_q                            RAM port read data
//
// state | meaning
// ------+------------------------------------------
// IDLE  | no access in flight, arbitration runs
// ADDR  | RAM port driven, RAM samples at end of cycle
// LAT   | ram_q valid, captured into the winner's dout
// HOLD  | ok/dout held until cs drops or addr/we change
module jtframe_dual_ram_arb #(
  parameter int dw = 8,
  parameter int aw = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_cs,
  input  logic          req1_cs,
  input  logic          req2_cs,
  input  logic [aw-1:0] req0_addr,
  input  logic [aw-1:0] req1_addr,
  input  logic [aw-1:0] req2_addr,
  input  logic [dw-1:0] req0_din,
  input  logic [dw-1:0] req1_din,
  input  logic [dw-1:0] req2_din,
  input  logic          req0_we,
  input  logic          req1_we,
  input  logic          req2_we,
  output logic [dw-1:0] req0_dout,
  output logic [dw-1:0] req1_dout,
  output logic [dw-1:0] req2_dout,
  output logic          req0_ok,
  output logic          req1_ok,
  output logic          req2_ok,
  output logic [aw-1:0] ram_addr,
  output logic [dw-1:0] ram_data,
  output logic          ram_we,
  input  logic [dw-1:0] ram_q
);

  typedef enum logic [1:0] {IDLE, ADDR, LAT, HOLD} state_t;

  state_t        state, state_nxt;
  logic [1:0]    gnt, gnt_nxt, last, last_nxt;
  logic [aw-1:0] lat_addr, lat_addr_nxt;
  logic          lat_we, lat_we_nxt;
  logic [aw-1:0] ram_addr_nxt;
  logic [dw-1:0] ram_data_nxt;
  logic          ram_we_nxt;
  logic [2:0]    ok, ok_nxt;
  logic [dw-1:0] dout [3];
  logic [dw-1:0] dout_nxt [3];

  logic [2:0]    cs_v;
  logic [1:0]    c1, c2, win;
  logic          win_ok;
  logic [aw-1:0] win_addr, sel_addr;
  logic [dw-1:0] win_din;
  logic          win_we, sel_cs, sel_we;
  logic [2:0]    gnt_oh;

  assign cs_v = {req2_cs, req1_cs, req0_cs};

  // scan order starts one past the last grant, wrapping modulo 3
  assign c1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
  assign c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;

  always_comb begin
    win_ok = 1'b1;
    win    = last;
    if (cs_v[c1])        win = c1;
    else if (cs_v[c2])   win = c2;
    else if (cs_v[last]) win = last;
    else                 win_ok = 1'b0;
  end

  always_comb begin
    case (win)
      2'd1:    begin win_addr = req1_addr; win_din = req1_din; win_we = req1_we; end
      2'd2:    begin win_addr = req2_addr; win_din = req2_din; win_we = req2_we; end
      default: begin win_addr = req0_addr; win_din = req0_din; win_we = req0_we; end
    endcase
  end

  always_comb begin
    case (gnt)
      2'd1:    begin sel_cs = req1_cs; sel_addr = req1_addr; sel_we = req1_we; end
      2'd2:    begin sel_cs = req2_cs; sel_addr = req2_addr; sel_we = req2_we; end
      default: begin sel_cs = req0_cs; sel_addr = req0_addr; sel_we = req0_we; end
    endcase
  end

  assign gnt_oh = 3'b001 << gnt;

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_nxt     = last;
    lat_addr_nxt = lat_addr;
    lat_we_nxt   = lat_we;
    ram_addr_nxt = ram_addr;
    ram_data_nxt = ram_data;
    ram_we_nxt   = 1'b0;
    ok_nxt       = ok;
    for (int i = 0; i < 3; i++) dout_nxt[i] = dout[i];

    case (state)
      IDLE: begin
        if (win_ok) begin
          gnt_nxt      = win;
          last_nxt     = win;
          lat_addr_nxt = win_addr;
          lat_we_nxt   = win_we;
          ram_addr_nxt = win_addr;
          ram_data_nxt = win_din;
          ram_we_nxt   = win_we;
          state_nxt    = ADDR;
        end
      end
      ADDR: state_nxt = LAT;
      LAT: begin
        for (int i = 0; i < 3; i++)
          if (gnt_oh[i]) dout_nxt[i] = ram_q;
        // an abandoned request (cs already low) never sees ok
        ok_nxt    = sel_cs ? gnt_oh : 3'b000;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (!sel_cs || sel_addr != lat_addr || sel_we != lat_we) begin
          ok_nxt    = 3'b000;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 2'd0;
      last     <= 2'd2;
      lat_addr <= '0;
      lat_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_we   <= 1'b0;
      ok       <= 3'b000;
      for (int i = 0; i < 3; i++) dout[i] <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last     <= last_nxt;
      lat_addr <= lat_addr_nxt;
      lat_we   <= lat_we_nxt;
      ram_addr <= ram_addr_nxt;
      ram_data <= ram_data_nxt;
      ram_we   <= ram_we_nxt;
      ok       <= ok_nxt;
      for (int i = 0; i < 3; i++) dout[i] <= dout_nxt[i];
    end
  end

  assign req0_ok   = ok[0];
  assign req1_ok   = ok[1];
  assign req2_ok   = ok[2];
  assign req0_dout = dout[0];
  assign req1_dout = dout[1];
  assign req2_dout = dout[2];

endmodule

// File: doc/jtframe_dual_ram_arb.md
# jtframe_dual_ram_arb

Three-requester round-robin arbiter that shares one port of a `jtframe_dual_ram` instance. CPU, DMA and debug logic each use a cs/ok handshake. The arbiter drives the RAM port address, data and write enable, waits out the RAM's one-cycle registered read latency, and returns read data to the granted requester. The other RAM port stays free for a video or sound reader on its own clock.

## Interface
Parameters:
- `dw`, 8, data width; must match the RAM instance.
- `aw`, 10, address width; must match the RAM instance.

Ports:
- `clk`  in  1  clock; also drives the RAM port's clock input.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req0_cs`, `req1_cs`, `req2_cs`  in  1 each  access request; held high until `ok` is seen.
- `req0_addr`, `req1_addr`, `req2_addr`  in  aw each  requested address.
- `req0_din`, `req1_din`, `req2_din`  in  dw each  write data.
- `req0_we`, `req1_we`, `req2_we`  in  1 each  1 = write, 0 = read.
- `req0_dout`, `req1_dout`, `req2_dout`  out  dw each  read data; valid while the matching `ok` is high.
- `req0_ok`, `req1_ok`, `req2_ok`  out  1 each  access complete.
- `ram_addr`  out  aw  to the RAM port's `addr`.
- `ram_data`  out  dw  to the RAM port's `data`.
- `ram_we`  out  1  to the RAM port's `we`.
- `ram_q`  in  dw  from the RAM port's `q`.

## Operation
- FSM states:
  - IDLE: no access in flight.
  - ADDR: RAM port is being driven.
  - LAT: RAM latency cycle.
  - HOLD: result held for the requester.
- All outputs are registered.
- IDLE:
  - Arbitration runs among requesters with `cs` high.
  - Priority is round-robin, starting at `last+1` mod 3, where `last` is the most recent grant.
  - On a grant:
    - latch the requester's index `gnt`, plus its `addr` and `we`;
    - drive `ram_addr`, `ram_data` and `ram_we` from the winner;
    - set `last` to `gnt`;
    - go to ADDR.
  - With no `cs` high, stay in IDLE; `ram_we` is 0.
- ADDR:
  - The RAM samples its inputs at the end of this cycle.
  - Next cycle `ram_we` returns to 0, so a write lasts exactly one cycle.
  - Go to LAT.
- LAT:
  - `ram_q` is now valid.
  - Capture `ram_q` into `reqN_dout[gnt]`.
  - Set `reqN_ok[gnt]` to 1.
  - Go to HOLD.
  - For writes, `dout` also captures `ram_q`, which holds the pre-write contents.
- HOLD: `ok` and `dout` stay stable. Go to IDLE and clear `ok` when either:
  - `cs[gnt]` is low; or
  - `addr[gnt]` or `we[gnt]` differs from the latched value. That is a new access, which competes again in IDLE.
- Requester rules:
  - `addr`, `din` and `we` must stay stable while `cs` is high and `ok` is low.
  - Dropping `cs` before `ok` abandons the result:
    - the access still completes to the RAM;
    - `ok` never rises;
    - leaving HOLD follows the HOLD rule, since `cs` is low.
- Only one `ok` is ever high at a time. `dout` for requesters that are not granted keeps its last value.

## Timing
- Reset, when `rst_n` is sampled low:
  - state goes to IDLE;
  - all `reqN_ok`, `ram_we`, `ram_addr` and `ram_data` go to 0;
  - all `reqN_dout` go to 0;
  - `last` is set to 2, so req0 has top priority first.
- Reset in mid-operation aborts the access. If reset hits in ADDR, a write may already have been sampled by the RAM.
- Latency:
  - `cs` sampled in IDLE at edge E0;
  - RAM samples its inputs at E1;
  - `ok` and `dout` are valid after E2.
  - This gives 3 cycles of latency.
- Minimum spacing for back-to-back accesses:
  - A requester can drop `cs` in the cycle after `ok`.
  - HOLD then exits at the next edge.
  - IDLE grants the next access one edge later.
  - This gives 5 cycles per access, for the same or a different requester.
- Simultaneous requests are served in round-robin order. A requester that is waiting is granted within 2 other accesses, so there is no starvation.
- A `cs` that rises while another access is in flight waits. Each `cs` change is seen only at IDLE sampling.
- Address wrap is native `aw`-bit and needs no special handling.

## Test plan
- After reset with `mem[5]` preset to 8'hA5, req0 reads addr 5 → `req0_ok` is high 3 cycles after `cs`, `req0_dout` = 8'hA5, `req1_ok` and `req2_ok` stay 0.
- req1 writes 8'h3C to addr 10 and gets `ok`, then reads addr 10 → `ram_we` is high for exactly one cycle; the read returns 8'h3C.
- All three `cs` are raised together and held, each dropping `cs` after its `ok` → grants come in the order 0, 1, 2. req0 then re-requests while req2 is in HOLD and is granted next.
- req2 holds `cs` and changes `addr` from 3 to 4 while in HOLD → `ok` drops the next cycle, then rises again with `mem[4]`.
- `rst_n` is pulled low during LAT of a req1 read → `req1_ok` never rises, every output is 0 after the reset edge, and a following req0 read completes normally.
- req0 drops `cs` during ADDR → `req0_ok` stays 0, the FSM returns to IDLE, and a pending req1 request is granted.
